// File: rtl/posit_defines.sv
// Shared constants for the ES2 posit accumulator and its encoders.
package posit_defines;

  // Accumulator fraction width (hidden bit excluded) and its serialized form:
  // {sgn, scale[7:0], fraction[FBITS_ACCUM-1:0], inf, zero}.
  localparam int unsigned FBITS_ACCUM = 32;
  localparam int unsigned POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = FBITS_ACCUM + 11;

  localparam logic [15:0] POSIT16_MAXPOS = 16'h7FFF;
  localparam logic [15:0] POSIT16_MINPOS = 16'h0001;
  localparam logic [15:0] POSIT16_NAR    = 16'h8000;
  localparam int          POSIT16_MAX_SCALE = 56;

  // Right-shift distance that turns the two-bit regime seed into a full regime:
  // k >= 0 needs k extra ones, k < 0 needs (-k - 1) extra zeros (= ~k).
  function automatic logic [7:0] regime_shamt(input logic signed [7:0] k);
    return k[7] ? ~k : k;
  endfunction

endpackage

// File: rtl/shift_right.sv
// Arithmetic right shift: vacated top bits are filled with a[N-1].
module shift_right #(
  parameter int unsigned N = 32,
  parameter int unsigned S = 8
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  assign c = $signed(a) >>> b;

endmodule

// File: rtl/posit16_es2_from_accum.sv
// Pipelined encoder: serialized ES2 accumulator value -> 16-bit posit (es = 2),
// round to nearest even, clamped to +/-maxpos and +/-minpos.
module posit16_es2_from_accum
  import posit_defines::*;
#(
  parameter int unsigned FBITS = FBITS_ACCUM,
  parameter int unsigned NBITS = 16,
  parameter int unsigned ES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FBITS+10:0] in1,
  output logic [15:0]      result,
  output logic             sat,
  output logic             done
);

  localparam int unsigned W   = FBITS + 11;
  localparam int unsigned N   = 2 * 16 + FBITS;
  localparam int unsigned Pad = N - FBITS - 4;
  localparam logic signed [7:0] MaxScale = 8'(POSIT16_MAX_SCALE);
  localparam logic signed [7:0] MinScale = -MaxScale;

  if (NBITS != 16 || ES != 2) begin : g_unsupported
    $error("posit16_es2_from_accum supports only NBITS=16, ES=2");
  end

  // ---------------- S0: input register ----------------
  logic [W-1:0] in_q;
  logic         v0_q;

  // Capture the serialized operand and its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= '0;
      v0_q <= 1'b0;
    end else begin
      in_q <= in1;
      v0_q <= start;
    end
  end

  // ---------------- S1: regime/exponent alignment ----------------
  logic signed [7:0] scale0, k0;
  logic [N-1:0]      seed0, shifted0;

  assign scale0 = in_q[W-2 -: 8];
  assign k0     = scale0 >>> 2;
  // Seed "10" (k >= 0) or "01" (k < 0); the arithmetic shift replicates the
  // leading bit to grow the regime run to its full length.
  assign seed0  = {~k0[7], k0[7], scale0[1:0], in_q[FBITS+1:2], {Pad{1'b0}}};

  shift_right #(.N(N), .S(8)) u_align (
    .a(seed0),
    .b(regime_shamt(k0)),
    .c(shifted0)
  );

  logic [14:0] mag1_q;
  logic        guard1_q, sticky1_q, over1_q, at_max1_q, under1_q;
  logic        sgn1_q, inf1_q, zero1_q, v1_q;

  // Register the truncated magnitude, rounding bits and range/special flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag1_q    <= '0;
      guard1_q  <= 1'b0;
      sticky1_q <= 1'b0;
      over1_q   <= 1'b0;
      at_max1_q <= 1'b0;
      under1_q  <= 1'b0;
      sgn1_q    <= 1'b0;
      inf1_q    <= 1'b0;
      zero1_q   <= 1'b0;
      v1_q      <= 1'b0;
    end else begin
      mag1_q    <= shifted0[N-1 -: 15];
      guard1_q  <= shifted0[N-16];
      sticky1_q <= |shifted0[N-17:0];
      over1_q   <= scale0 > MaxScale;
      at_max1_q <= scale0 == MaxScale;
      under1_q  <= scale0 < MinScale;
      sgn1_q    <= in_q[W-1];
      inf1_q    <= in_q[1];
      zero1_q   <= in_q[0];
      v1_q      <= v0_q;
    end
  end

  // ---------------- S2: round and saturate ----------------
  logic        inc2, sat_hi2, sat_lo2;
  logic [15:0] sum2;
  logic [14:0] mag2;

  // Round to nearest even, then clamp into [minpos, maxpos].
  always_comb begin
    inc2    = guard1_q & (sticky1_q | mag1_q[0]);
    sum2    = {1'b0, mag1_q} + {15'd0, inc2};
    // At scale 56 the regime fills all 15 bits, so any remainder means the
    // value lies above maxpos.
    sat_hi2 = over1_q | sum2[15] | (at_max1_q & (guard1_q | sticky1_q));
    sat_lo2 = under1_q | (sum2[14:0] == 15'd0);
    mag2    = sum2[14:0];
    if (sat_hi2) begin
      mag2 = POSIT16_MAXPOS[14:0];
    end else if (sat_lo2) begin
      mag2 = POSIT16_MINPOS[14:0];
    end
  end

  logic [14:0] mag2_q;
  logic        sat2_q, sgn2_q, inf2_q, zero2_q, v2_q;

  // Register the final magnitude and the clamp flag (never set for specials).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag2_q  <= '0;
      sat2_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      inf2_q  <= 1'b0;
      zero2_q <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      mag2_q  <= mag2;
      sat2_q  <= (sat_hi2 | sat_lo2) & ~zero1_q & ~inf1_q;
      sgn2_q  <= sgn1_q;
      inf2_q  <= inf1_q;
      zero2_q <= zero1_q;
      v2_q    <= v1_q;
    end
  end

  // ---------------- S3: sign and specials ----------------
  logic [15:0] pat2;

  // Zero wins over NaR; sign only applies to finite nonzero values.
  always_comb begin
    pat2 = {1'b0, mag2_q};
    if (zero2_q) begin
      pat2 = 16'h0000;
    end else if (inf2_q) begin
      pat2 = POSIT16_NAR;
    end else if (sgn2_q) begin
      pat2 = 16'h0000 - {1'b0, mag2_q};
    end
  end

  logic [15:0] pat3_q;
  logic        sat3_q, v3_q;

  // Register the signed posit pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat3_q <= '0;
      sat3_q <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      pat3_q <= pat2;
      sat3_q <= sat2_q;
      v3_q   <= v2_q;
    end
  end

  // Output register; result/sat hold between conversions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 16'h0000;
      sat    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= v3_q;
      if (v3_q) begin
        result <= pat3_q;
        sat    <= sat3_q;
      end
    end
  end

endmodule

// File: tb/tb_posit16_es2_from_accum.sv
// Directed-vector bench for posit16_es2_from_accum with a bit-string model.
module tb_posit16_es2_from_accum;
  import posit_defines::*;

  localparam int unsigned FB = FBITS_ACCUM;
  localparam int unsigned W  = FB + 11;

  logic         clk, rst, start;
  logic [W-1:0] in1;
  logic [15:0]  result;
  logic         sat, done;

  posit16_es2_from_accum #(.FBITS(FB), .NBITS(16), .ES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1),
    .result(result), .sat(sat), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] r;
    logic        s;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [W-1:0] mk(input bit sg, input int sc, input logic [FB-1:0] fr,
                                      input bit inf, input bit zr);
    logic [7:0] s8;
    s8 = sc[7:0];
    return {sg, s8, fr, inf, zr};
  endfunction

  // Encode by literally writing out the posit bit string and rounding on it.
  function automatic void model(input logic [W-1:0] v, output logic [15:0] r, output logic st);
    bit q[$];
    logic [7:0]    s8;
    logic [FB-1:0] fr;
    logic [14:0]   m;
    int s, k, e, rnd;
    bit g, stk;
    s8 = v[W-2 -: 8];
    s  = int'($signed(s8));
    fr = v[FB+1:2];
    st = 1'b0;
    if (v[0]) begin r = 16'h0000; return; end
    if (v[1]) begin r = 16'h8000; return; end
    k = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    e = s - 4 * k;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    q.push_back(e[1]);
    q.push_back(e[0]);
    for (int i = FB - 1; i >= 0; i--) q.push_back(fr[i]);
    while (q.size() < 17) q.push_back(1'b0);
    m = '0;
    for (int i = 0; i < 15; i++) m = {m[13:0], q[i]};
    g = q[15];
    stk = 1'b0;
    for (int i = 16; i < q.size(); i++) stk = stk | q[i];
    rnd = int'(m) + ((g && (stk || m[0])) ? 1 : 0);
    if (s > 56 || (s == 56 && fr != '0) || rnd > 32767) begin
      m = 15'h7FFF; st = 1'b1;
    end else if (s < -56 || rnd == 0) begin
      m = 15'h0001; st = 1'b1;
    end else begin
      m = rnd[14:0];
    end
    r = v[W-1] ? (16'h0000 - {1'b0, m}) : {1'b0, m};
  endfunction

  // Drive one start; optionally pin the model against a hand-computed answer.
  task automatic send(input logic [W-1:0] v, input bit lit, input logic [15:0] lr,
                      input logic ls, input string nm);
    logic [15:0] r;
    logic s;
    exp_t x;
    model(v, r, s);
    if (lit) begin
      checks++;
      if (r !== lr || s !== ls) begin
        errors++;
        $display("FAIL model %s: got %h sat %b, want %h sat %b", nm, r, s, lr, ls);
      end
    end
    @(negedge clk);
    start = 1'b1;
    in1   = v;
    x.r = r; x.s = s; x.cyc = cyc + 5; x.nm = nm;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", nm, done); end
    if (result !== 16'h0000) begin
      errors++; $display("FAIL %s result: got %h want 0000", nm, result);
    end
    if (sat !== 1'b0) begin errors++; $display("FAIL %s sat: got %b want 0", nm, sat); end
  endtask

  // Check every done pulse against the model queue, including its latency.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected done: result %h sat %b, want no done", result, sat);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (result !== x.r || sat !== x.s || cyc != x.cyc) begin
          errors++;
          $display("FAIL %s: got %h sat %b cyc %0d, want %h sat %b cyc %0d",
                   x.nm, result, sat, cyc, x.r, x.s, x.cyc);
        end
      end
    end
  end

  localparam logic [FB-1:0] FMsb = FB'(1) << (FB - 1);
  localparam logic [FB-1:0] F11  = FB'(1) << (FB - 11);
  localparam logic [FB-1:0] F12  = FB'(1) << (FB - 12);
  localparam logic [FB-1:0] F13  = FB'(1) << (FB - 13);
  localparam logic [FB-1:0] FOne = '1;

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0;
    #12;
    chk_reset("reset");
    #10 rst = 1'b0;

    send(mk(0, 0, '0, 0, 0),    1, 16'h4000, 1'b0, "unity");
    idle(6);
    send(mk(0, 0, FMsb, 0, 0),  1, 16'h4400, 1'b0, "one_half");
    send(mk(1, 0, FMsb, 0, 0),  1, 16'hBC00, 1'b0, "neg_one_half");
    send(mk(0, 4, '0, 0, 0),    1, 16'h6000, 1'b0, "sixteen");
    send(mk(0, -1, '0, 0, 0),   1, 16'h3800, 1'b0, "half");
    send(mk(0, 2, '0, 0, 0),    1, 16'h5000, 1'b0, "four");
    send(mk(0, 0, F12, 0, 0),   1, 16'h4000, 1'b0, "tie_even");
    send(mk(0, 0, F12 | F13, 0, 0), 1, 16'h4001, 1'b0, "round_up");
    send(mk(0, 0, F11 | F12, 0, 0), 1, 16'h4002, 1'b0, "tie_odd");
    send(mk(0, 60, '0, 0, 0),   1, 16'h7FFF, 1'b1, "sat_max");
    send(mk(1, -60, '0, 0, 0),  1, 16'hFFFF, 1'b1, "sat_min_neg");
    send(mk(0, 56, FOne, 0, 0), 1, 16'h7FFF, 1'b1, "max_frac");
    send(mk(0, 56, '0, 0, 0),   1, 16'h7FFF, 1'b0, "maxpos_exact");
    send(mk(0, -56, '0, 0, 0),  1, 16'h0001, 1'b0, "minpos_exact");
    send(mk(0, -57, '0, 0, 0),  1, 16'h0001, 1'b1, "below_minpos");
    send(mk(1, 5, FMsb, 1, 1),  1, 16'h0000, 1'b0, "zero_over_inf");
    send(mk(1, 5, FMsb, 1, 0),  1, 16'h8000, 1'b0, "nar");
    idle(1);
    drain();

    // Ten back-to-back mixed conversions, checked against the model only.
    for (int i = 0; i < 10; i++) begin
      logic [FB-1:0] fr;
      int sc;
      fr = FB'({$urandom, $urandom});
      sc = (i == 9) ? 3 : int'($urandom_range(0, 120)) - 60;
      send(mk(i[0], sc, fr, (i == 4), (i == 7)), 0, 16'h0, 1'b0, $sformatf("stream%0d", i));
    end
    idle(1);
    drain();

    // Reset mid-flight: three conversions are dropped.
    send(mk(0, 8, FMsb, 0, 0),  0, 16'h0, 1'b0, "drop0");
    send(mk(1, -3, F12, 0, 0),  0, 16'h0, 1'b0, "drop1");
    send(mk(0, 20, F11, 0, 0),  0, 16'h0, 1'b0, "drop2");
    @(posedge clk);
    #2 start = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_reset("mid_reset");
    exp_q.delete();
    rst = 1'b0;
    idle(12);
    send(mk(0, -1, '0, 0, 0),   1, 16'h3800, 1'b0, "after_reset");
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
